// File: rtl/regs_pkg.sv
// Shared constants and address type for the multi-port register file.
package regs_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_REG_NUM = 32;
  localparam int unsigned DEF_ADDR_W  = $clog2(DEF_REG_NUM);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regs_wr_arb.sv
// Resolves NUM_WR write ports into per-register enable, data and clear.
// Highest port index wins data; any clearing port clears. x0 never gets an enable.
module regs_wr_arb
  import regs_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned REG_NUM = DEF_REG_NUM,
  parameter int unsigned NUM_WR  = 1,
  parameter int unsigned ADDR_W  = $clog2(REG_NUM)
) (
  input  logic [NUM_WR-1:0]               we_i,
  input  logic [NUM_WR*ADDR_W-1:0]        waddr_i,
  input  logic [NUM_WR*DATA_W-1:0]        wdata_i,
  input  logic [NUM_WR-1:0]               wclr_i,
  output logic [REG_NUM-1:0]              reg_we_o,
  output logic [REG_NUM-1:0][DATA_W-1:0]  reg_wdata_o,
  output logic [REG_NUM-1:0]              reg_clr_o
);

  always_comb begin
    reg_we_o    = '0;
    reg_wdata_o = '0;
    reg_clr_o   = '0;
    for (int r = 0; r < int'(REG_NUM); r++) begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) &&
            (ADDR_W'(r) != ADDR_W'(ZERO_REG))) begin
          reg_we_o[r]    = 1'b1;
          reg_wdata_o[r] = wdata_i[k*DATA_W +: DATA_W];
          if (wclr_i[k]) begin
            reg_clr_o[r] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regs_mp.sv
// Multi-port register file with busy scoreboard and issue handshake; x0 reads zero.
// Optional REGS_MP_BYPASS_EN adds same-cycle write-to-read forwarding and busy/ready masking.
module regs_mp
  import regs_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned REG_NUM = DEF_REG_NUM,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_WR  = 1,
  parameter int unsigned ADDR_W  = $clog2(REG_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         we_i,
  input  logic [NUM_WR*ADDR_W-1:0]  waddr_i,
  input  logic [NUM_WR*DATA_W-1:0]  wdata_i,
  input  logic [NUM_WR-1:0]         wclr_i,
  input  logic [NUM_RD*ADDR_W-1:0]  raddr_i,
  output logic [NUM_RD*DATA_W-1:0]  rdata_o,
  output logic [NUM_RD-1:0]         rbusy_o,
  input  logic                      iss_valid_i,
  input  logic [ADDR_W-1:0]         iss_addr_i,
  output logic                      iss_ready_o,
  input  logic                      flush_i
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(ZERO_REG);

  logic [REG_NUM-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [REG_NUM-1:0]             busy_q, busy_d;

  logic [REG_NUM-1:0]             reg_we;
  logic [REG_NUM-1:0][DATA_W-1:0] reg_wdata;
  logic [REG_NUM-1:0]             reg_clr;
  logic                           iss_fire;

  regs_wr_arb #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM),
    .NUM_WR  (NUM_WR),
    .ADDR_W  (ADDR_W)
  ) u_wr_arb (
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .wclr_i      (wclr_i),
    .reg_we_o    (reg_we),
    .reg_wdata_o (reg_wdata),
    .reg_clr_o   (reg_clr)
  );

  // Issue acceptance: blocks WAW on a busy destination unless it clears now.
  always_comb begin
    iss_ready_o = 1'b0;
    if (!rst && !flush_i) begin
`ifdef REGS_MP_BYPASS_EN
      iss_ready_o = (iss_addr_i == X0) || !busy_q[iss_addr_i] || reg_clr[iss_addr_i];
`else
      iss_ready_o = (iss_addr_i == X0) || !busy_q[iss_addr_i];
`endif
    end
  end

  assign iss_fire = iss_valid_i && iss_ready_o;

  // Read ports: x0 is zero, then optional forwarding, then the array.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int j = 0; j < int'(NUM_RD); j++) begin
      logic [ADDR_W-1:0] ra;
      ra = raddr_i[j*ADDR_W +: ADDR_W];
      if (!rst && (ra != X0)) begin
`ifdef REGS_MP_BYPASS_EN
        rdata_o[j*DATA_W +: DATA_W] = reg_we[ra] ? reg_wdata[ra] : regs_q[ra];
        rbusy_o[j]                  = busy_q[ra] && !reg_clr[ra];
`else
        rdata_o[j*DATA_W +: DATA_W] = regs_q[ra];
        rbusy_o[j]                  = busy_q[ra];
`endif
      end
    end
  end

  // Next state: array write, then scoreboard clear < set < flush.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 0; r < int'(REG_NUM); r++) begin
      if (reg_we[r]) begin
        regs_d[r] = reg_wdata[r];
      end
      if (reg_clr[r]) begin
        busy_d[r] = 1'b0;
      end
      if (iss_fire && (iss_addr_i == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    if (flush_i) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule
